// File: rtl/alu_seq_core.sv
// Sequential ALU: single-cycle logic/arith/shift ops, signed saturating add/sub and an
// iterative shift-add multiply, frozen by a synchronous hold input. start/busy/done handshake.
module alu_seq_core #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    input  logic             start,
    input  logic             hold,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] clamp_obs
);

    // Handshake: a request is taken on a rising edge where start=1, hold=0 and the FSM is
    // IDLE; done is high for the cycle after a completion edge (stretched while hold=1).
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_SADD = 4'd9;
    localparam logic [3:0] OP_SSUB = 4'd10;

    localparam int               CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] clamp_q, clamp_d;

    logic [SHW-1:0]   sh_amt;
    logic             sh_big;
    logic [WIDTH:0]   sat_sum;
    logic [WIDTH-1:0] op_res;
    logic             op_ovf;
    logic [WIDTH-1:0] op_clamp;
    logic [WIDTH-1:0] acc_step;

    assign sh_amt = b[SHW-1:0];
    assign sh_big = (int'(sh_amt) >= WIDTH);

    // Single-cycle datapath; clamp_obs mirrors the result except for saturating ops.
    always_comb begin
        op_res   = '0;
        op_ovf   = 1'b0;
        sat_sum  = '0;
        case (opcode)
            OP_ADD: op_res = a + b;
            OP_SUB: op_res = a - b;
            OP_AND: op_res = a & b;
            OP_OR:  op_res = a | b;
            OP_XOR: op_res = a ^ b;
            OP_SHL: op_res = sh_big ? '0 : (a << sh_amt);
            OP_SHR: op_res = sh_big ? '0 : (a >> sh_amt);
            OP_SRA: op_res = sh_big ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> sh_amt);
            OP_SADD, OP_SSUB: begin
                if (opcode == OP_SSUB) begin
                    sat_sum = {a[WIDTH-1], a} - {b[WIDTH-1], b};
                end else begin
                    sat_sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
                end
                if (sat_sum[WIDTH] != sat_sum[WIDTH-1]) begin
                    op_ovf = 1'b1;
                    op_res = sat_sum[WIDTH] ? SAT_MIN : SAT_MAX;
                end else begin
                    op_res = sat_sum[WIDTH-1:0];
                end
            end
            default: op_res = '0;
        endcase
        op_clamp = ((opcode == OP_SADD) || (opcode == OP_SSUB)) ? sat_sum[WIDTH-1:0] : op_res;
    end

    // One shift-add step: multiplier consumed LSB first, multiplicand shifts left.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        result_d = result_q;
        clamp_d  = clamp_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (opcode == OP_MUL) begin
                        state_d  = ST_MUL;
                        mcand_d  = a;
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        result_d = op_res;
                        ovf_d    = op_ovf;
                        clamp_d  = op_clamp;
                        done_d   = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    result_d = acc_step;
                    ovf_d    = 1'b0;
                    clamp_d  = acc_step;
                    done_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // hold acts as a clock enable for every register, including the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            clamp_q  <= '0;
        end else if (!hold) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            clamp_q  <= clamp_d;
        end
    end

    assign busy      = (state_q == ST_MUL);
    assign done      = done_q;
    assign ovf       = ovf_q;
    assign result    = result_q;
    assign clamp_obs = clamp_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core: expected {result, ovf, clamp_obs} queued at issue,
// popped and compared by a monitor whenever a done pulse is consumed.
module tb_alu_seq_core;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   opcode = '0;
    logic         start = 1'b0;
    logic         hold = 1'b0;
    logic         busy;
    logic         done;
    logic         ovf;
    logic [W-1:0] result;
    logic [W-1:0] clamp_obs;

    logic [2*W:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    alu_seq_core #(.WIDTH(W), .SHW(4)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .opcode(opcode), .start(start),
        .hold(hold), .busy(busy), .done(done), .ovf(ovf), .result(result),
        .clamp_obs(clamp_obs)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Issue one request; caller is #1 after an edge with FSM idle and hold=0.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] er, input logic eo, input logic [W-1:0] ec);
        a = av;
        b = bv;
        opcode = op;
        start = 1'b1;
        exp_q.push_back({er, eo, ec});
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // A done pulse is consumed on the next edge only if hold is low there.
    always @(negedge clk) begin
        if (rst_n && done && !hold) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual result=%0h expected no completion", result);
            end else begin
                logic [2*W:0] e;
                e = exp_q.pop_front();
                check("result", result, e[2*W:W+1]);
                check("ovf", ovf, e[W]);
                check("clamp_obs", clamp_obs, e[W-1:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        check("rst_result", result, 0);
        check("rst_clamp", clamp_obs, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(4'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 16'h0000);
        check("add_done_hi", done, 1);
        @(posedge clk);
        #1;
        check("add_done_lo", done, 0);

        // Back-to-back single-cycle ops, start held across done cycles.
        issue(4'd1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 16'hFFFE);
        issue(4'd2, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 16'h3030);
        issue(4'd3, 16'hF0F0, 16'h3C3C, 16'hFCFC, 1'b0, 16'hFCFC);
        issue(4'd4, 16'hF0F0, 16'h3C3C, 16'hCCCC, 1'b0, 16'hCCCC);
        issue(4'd5, 16'h0001, 16'h000F, 16'h8000, 1'b0, 16'h8000);
        issue(4'd6, 16'h8000, 16'h0004, 16'h0800, 1'b0, 16'h0800);
        issue(4'd7, 16'h8000, 16'h000F, 16'hFFFF, 1'b0, 16'hFFFF);
        issue(4'd7, 16'h8000, 16'h0004, 16'hF800, 1'b0, 16'hF800);
        issue(4'd12, 16'h1234, 16'h5678, 16'h0000, 1'b0, 16'h0000);
        check("rsv_done", done, 1);
        issue(4'd9, 16'h7FF0, 16'h0020, 16'h7FFF, 1'b1, 16'h8010);
        issue(4'd10, 16'h8000, 16'h0001, 16'h8000, 1'b1, 16'h7FFF);
        issue(4'd9, 16'h8000, 16'h8000, 16'h8000, 1'b1, 16'h0000);
        issue(4'd9, 16'hFFFF, 16'h0002, 16'h0001, 1'b0, 16'h0001);
        issue(4'd10, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 16'hFFFE);
        issue(4'd9, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1, 16'h8000);
        issue(4'd0, 16'h0002, 16'h0003, 16'h0005, 1'b0, 16'h0005);
        @(posedge clk);
        #1;

        // MUL with an ADD request thrown in while busy; it must be dropped.
        issue(4'd8, 16'h0123, 16'h0045, 16'h4E6F, 1'b0, 16'h4E6F);
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (n == 5) begin
                opcode = 4'd0;
                a = 16'h1111;
                b = 16'h1111;
                start = 1'b1;
            end
            if (n == 6) start = 1'b0;
            @(posedge clk);
            #1;
        end
        check("mul_busy_cycles", n, 16);
        check("mul_done_hi", done, 1);
        @(posedge clk);
        #1;
        check("mul_done_lo", done, 0);

        // MUL with three held edges in the middle: done 19 edges after accept.
        issue(4'd8, 16'h0003, 16'h0005, 16'h000F, 1'b0, 16'h000F);
        n = 0;
        for (int e = 1; e <= 40; e++) begin
            if (e == 5) hold = 1'b1;
            if (e == 8) hold = 1'b0;
            @(posedge clk);
            #1;
            if (done) begin
                n = e;
                break;
            end
        end
        check("mul_hold_latency", n, 19);
        @(posedge clk);
        #1;

        // done pulse stretched by hold, cleared by first un-held edge.
        issue(4'd0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 16'h0002);
        hold = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("hold_done_stretch", done, 1);
        hold = 1'b0;
        @(posedge clk);
        #1;
        check("hold_done_clear", done, 0);

        // Reset in the middle of a multiply: abandoned, no completion.
        a = 16'h0123;
        b = 16'h0045;
        opcode = 4'd8;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_ovf", ovf, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_clamp", clamp_obs, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_idle", busy, 0);
        issue(4'd0, 16'h0002, 16'h0003, 16'h0005, 1'b0, 16'h0005);

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
